aia_imsic_irq_tx: RTL and testbench



---
 rtl/aia_imsic_irq_tx.sv | 124 ++++++++++++
 tb/tb_aia_imsic_irq_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/aia_imsic_irq_tx.sv
// Per-hart IMSIC interrupt files: MSI writes set pending bits, topei/irq are combinational from state,
// claims are acked one cycle later; MSI is always accepted once out of reset (no backpressure).
module aia_imsic_irq_tx #(
  parameter int NrVSIntpFiles = 0,
  parameter int NrIntpFiles   = 2 + NrVSIntpFiles,
  parameter int NrSourcesW    = 5,
  parameter int FileW         = (NrIntpFiles > 2) ? $clog2(NrIntpFiles) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              msi_valid_i,
  output logic                              msi_ready_o,
  input  logic [FileW-1:0]                  msi_file_i,
  input  logic [NrSourcesW-1:0]             msi_id_i,
  input  logic                              cfg_we_i,
  input  logic [FileW-1:0]                  cfg_file_i,
  input  logic [1:0]                        cfg_sel_i,
  input  logic [NrSourcesW-1:0]             cfg_data_i,
  input  logic                              claim_valid_i,
  input  logic [FileW-1:0]                  claim_file_i,
  output logic                              claim_ack_o,
  output logic [NrSourcesW-1:0]             claim_id_o,
  output logic [NrIntpFiles*NrSourcesW-1:0] topei_o,
  output logic [NrIntpFiles-1:0]            irq_o
);

  localparam int NrIds = 2**NrSourcesW - 1;

  logic [NrIds:0]           eip_q [NrIntpFiles];
  logic [NrIds:0]           eip_d [NrIntpFiles];
  logic [NrIds:0]           eie_q [NrIntpFiles];
  logic [NrIds:0]           eie_d [NrIntpFiles];
  logic [NrSourcesW-1:0]    thr_q [NrIntpFiles];
  logic [NrSourcesW-1:0]    thr_d [NrIntpFiles];
  logic [NrIntpFiles-1:0]   dlv_q, dlv_d;
  logic                     rdy_q, rdy_d;
  logic                     ack_q, ack_d;
  logic [NrSourcesW-1:0]    cid_q, cid_d;
  logic [NrSourcesW-1:0]    top_id [NrIntpFiles];
  logic [NrSourcesW-1:0]    claim_top;

  // Scan downward so the last hit is the lowest (highest-priority) identity.
  always_comb begin
    for (int f = 0; f < NrIntpFiles; f++) begin
      top_id[f] = '0;
      for (int i = NrIds; i >= 1; i--) begin
        if (eip_q[f][i] && eie_q[f][i] &&
            ((thr_q[f] == '0) || (NrSourcesW'(i) < thr_q[f]))) begin
          top_id[f] = NrSourcesW'(i);
        end
      end
    end
  end

  always_comb begin
    claim_top = '0;
    for (int f = 0; f < NrIntpFiles; f++) begin
      if (claim_file_i == FileW'(f)) claim_top = top_id[f];
    end
  end

  always_comb begin
    rdy_d = 1'b1;
    ack_d = claim_valid_i;
    cid_d = claim_valid_i ? claim_top : '0;
    dlv_d = dlv_q;
    for (int f = 0; f < NrIntpFiles; f++) begin
      eip_d[f] = eip_q[f];
      eie_d[f] = eie_q[f];
      thr_d[f] = thr_q[f];
      if (claim_valid_i && (claim_file_i == FileW'(f))) eip_d[f][claim_top] = 1'b0;
      // Applied after the claim clear so a coincident MSI keeps the bit pending.
      if (msi_valid_i && rdy_q && (msi_file_i == FileW'(f))) eip_d[f][msi_id_i] = 1'b1;
      if (cfg_we_i && (cfg_file_i == FileW'(f))) begin
        case (cfg_sel_i)
          2'd0:    eie_d[f][cfg_data_i] = 1'b1;
          2'd1:    eie_d[f][cfg_data_i] = 1'b0;
          2'd2:    thr_d[f] = cfg_data_i;
          default: dlv_d[f] = cfg_data_i[0];
        endcase
      end
      eip_d[f][0] = 1'b0;
      eie_d[f][0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int f = 0; f < NrIntpFiles; f++) begin
        eip_q[f] <= '0;
        eie_q[f] <= '0;
        thr_q[f] <= '0;
      end
      dlv_q <= '0;
      rdy_q <= 1'b0;
      ack_q <= 1'b0;
      cid_q <= '0;
    end else begin
      for (int f = 0; f < NrIntpFiles; f++) begin
        eip_q[f] <= eip_d[f];
        eie_q[f] <= eie_d[f];
        thr_q[f] <= thr_d[f];
      end
      dlv_q <= dlv_d;
      rdy_q <= rdy_d;
      ack_q <= ack_d;
      cid_q <= cid_d;
    end
  end

  always_comb begin
    topei_o = '0;
    irq_o   = '0;
    for (int f = 0; f < NrIntpFiles; f++) begin
      topei_o[f*NrSourcesW +: NrSourcesW] = top_id[f];
      irq_o[f] = dlv_q[f] && (top_id[f] != '0);
    end
  end

  assign msi_ready_o = rdy_q;
  assign claim_ack_o = ack_q;
  assign claim_id_o  = cid_q;

endmodule

// File: tb/tb_aia_imsic_irq_tx.sv
// Directed bench for aia_imsic_irq_tx; FileW widened to 2 so file index 2 is encodable as out of range.
module tb_aia_imsic_irq_tx;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       msi_valid_i = 1'b0;
  logic       msi_ready_o;
  logic [1:0] msi_file_i = '0;
  logic [4:0] msi_id_i = '0;
  logic       cfg_we_i = 1'b0;
  logic [1:0] cfg_file_i = '0;
  logic [1:0] cfg_sel_i = '0;
  logic [4:0] cfg_data_i = '0;
  logic       claim_valid_i = 1'b0;
  logic [1:0] claim_file_i = '0;
  logic       claim_ack_o;
  logic [4:0] claim_id_o;
  logic [9:0] topei_o;
  logic [1:0] irq_o;
  logic [4:0] top0, top1;

  int tests = 0;
  int fails = 0;

  assign top0 = topei_o[4:0];
  assign top1 = topei_o[9:5];

  aia_imsic_irq_tx #(.NrVSIntpFiles(0), .NrSourcesW(5), .FileW(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .msi_valid_i(msi_valid_i), .msi_ready_o(msi_ready_o),
    .msi_file_i(msi_file_i), .msi_id_i(msi_id_i),
    .cfg_we_i(cfg_we_i), .cfg_file_i(cfg_file_i), .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i),
    .claim_valid_i(claim_valid_i), .claim_file_i(claim_file_i),
    .claim_ack_o(claim_ack_o), .claim_id_o(claim_id_o),
    .topei_o(topei_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input logic [1:0] f, input logic [1:0] sel, input logic [4:0] d);
    cfg_we_i = 1'b1; cfg_file_i = f; cfg_sel_i = sel; cfg_data_i = d;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic msi(input logic [1:0] f, input logic [4:0] id);
    msi_valid_i = 1'b1; msi_file_i = f; msi_id_i = id;
    tick();
    msi_valid_i = 1'b0;
  endtask

  task automatic claim(input logic [1:0] f);
    claim_valid_i = 1'b1; claim_file_i = f;
    tick();
    claim_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #10;
    tests++; if (msi_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", msi_ready_o); end
    tests++; if (claim_ack_o !== 1'b0 || claim_id_o !== 5'd0) begin fails++; $display("FAIL reset_claim: ack %b id %0d want 0/0", claim_ack_o, claim_id_o); end
    tests++; if (topei_o !== 10'd0 || irq_o !== 2'b00) begin fails++; $display("FAIL reset_top: topei %h irq %b want 0/0", topei_o, irq_o); end
    rst_ni = 1'b1;
    tick();
    tests++; if (msi_ready_o !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b want 1", msi_ready_o); end
  endtask

  task automatic test_basic_msi();
    cfg(2'd0, 2'd0, 5'd5);
    cfg(2'd0, 2'd3, 5'd1);
    tests++; if (top0 !== 5'd0 || irq_o !== 2'b00) begin fails++; $display("FAIL pre_msi: top0 %0d irq %b want 0/00", top0, irq_o); end
    msi(2'd0, 5'd5);
    tests++; if (top0 !== 5'd5 || irq_o[0] !== 1'b1) begin fails++; $display("FAIL msi_top0: top0 %0d irq0 %b want 5/1", top0, irq_o[0]); end
    tests++; if (top1 !== 5'd0 || irq_o[1] !== 1'b0) begin fails++; $display("FAIL msi_file1_idle: top1 %0d irq1 %b want 0/0", top1, irq_o[1]); end
    claim(2'd0);
    tests++; if (claim_ack_o !== 1'b1 || claim_id_o !== 5'd5) begin fails++; $display("FAIL claim5: ack %b id %0d want 1/5", claim_ack_o, claim_id_o); end
    tests++; if (top0 !== 5'd0 || irq_o[0] !== 1'b0) begin fails++; $display("FAIL claim5_cleared: top0 %0d irq0 %b want 0/0", top0, irq_o[0]); end
    tick();
    tests++; if (claim_ack_o !== 1'b0) begin fails++; $display("FAIL ack_single_cycle: got %b want 0", claim_ack_o); end
  endtask

  task automatic test_threshold();
    cfg(2'd1, 2'd0, 5'd3); cfg(2'd1, 2'd0, 5'd7); cfg(2'd1, 2'd0, 5'd12);
    msi(2'd1, 5'd12); msi(2'd1, 5'd7); msi(2'd1, 5'd3);
    cfg(2'd1, 2'd2, 5'd7);
    tests++; if (top1 !== 5'd3 || irq_o[1] !== 1'b0) begin fails++; $display("FAIL thr_top: top1 %0d irq1 %b want 3/0", top1, irq_o[1]); end
    claim(2'd1);
    tests++; if (claim_ack_o !== 1'b1 || claim_id_o !== 5'd3) begin fails++; $display("FAIL thr_claim: ack %b id %0d want 1/3", claim_ack_o, claim_id_o); end
    tests++; if (top1 !== 5'd0) begin fails++; $display("FAIL thr_blocked: top1 %0d want 0", top1); end
    cfg(2'd1, 2'd2, 5'd0);
    tests++; if (top1 !== 5'd7) begin fails++; $display("FAIL thr_off: top1 %0d want 7", top1); end
    cfg(2'd1, 2'd1, 5'd7); cfg(2'd1, 2'd1, 5'd12);
    tests++; if (top1 !== 5'd0) begin fails++; $display("FAIL eie_clear: top1 %0d want 0", top1); end
  endtask

  task automatic test_drop();
    msi(2'd0, 5'd0);
    tests++; if (topei_o !== 10'd0 || irq_o !== 2'b00) begin fails++; $display("FAIL drop_id0: topei %h irq %b want 0/00", topei_o, irq_o); end
    msi(2'd2, 5'd5);
    tests++; if (topei_o !== 10'd0 || irq_o !== 2'b00) begin fails++; $display("FAIL drop_file2: topei %h irq %b want 0/00", topei_o, irq_o); end
    msi(2'd3, 5'd5);
    tests++; if (topei_o !== 10'd0 || irq_o !== 2'b00) begin fails++; $display("FAIL drop_file3: topei %h irq %b want 0/00", topei_o, irq_o); end
  endtask

  task automatic test_claim_msi_same();
    cfg(2'd0, 2'd0, 5'd4);
    msi(2'd0, 5'd4);
    tests++; if (top0 !== 5'd4) begin fails++; $display("FAIL race_pre: top0 %0d want 4", top0); end
    claim_valid_i = 1'b1; claim_file_i = 2'd0;
    msi_valid_i = 1'b1; msi_file_i = 2'd0; msi_id_i = 5'd4;
    tick();
    claim_valid_i = 1'b0; msi_valid_i = 1'b0;
    tests++; if (claim_ack_o !== 1'b1 || claim_id_o !== 5'd4) begin fails++; $display("FAIL race_claim: ack %b id %0d want 1/4", claim_ack_o, claim_id_o); end
    tests++; if (top0 !== 5'd4) begin fails++; $display("FAIL race_set_wins: top0 %0d want 4", top0); end
    claim(2'd0);
    tests++; if (claim_id_o !== 5'd4 || top0 !== 5'd0) begin fails++; $display("FAIL race_reclaim: id %0d top0 %0d want 4/0", claim_id_o, top0); end
  endtask

  task automatic test_back_to_back();
    claim(2'd1);
    tests++; if (claim_ack_o !== 1'b1 || claim_id_o !== 5'd0) begin fails++; $display("FAIL empty_claim: ack %b id %0d want 1/0", claim_ack_o, claim_id_o); end
    claim(2'd2);
    tests++; if (claim_ack_o !== 1'b1 || claim_id_o !== 5'd0) begin fails++; $display("FAIL oor_claim: ack %b id %0d want 1/0", claim_ack_o, claim_id_o); end
    cfg(2'd1, 2'd0, 5'd2); cfg(2'd1, 2'd0, 5'd9);
    msi(2'd1, 5'd9); msi(2'd1, 5'd2);
    claim_valid_i = 1'b1; claim_file_i = 2'd1;
    tick();
    tests++; if (claim_ack_o !== 1'b1 || claim_id_o !== 5'd2) begin fails++; $display("FAIL b2b_first: ack %b id %0d want 1/2", claim_ack_o, claim_id_o); end
    tick();
    claim_valid_i = 1'b0;
    tests++; if (claim_ack_o !== 1'b1 || claim_id_o !== 5'd9) begin fails++; $display("FAIL b2b_second: ack %b id %0d want 1/9", claim_ack_o, claim_id_o); end
    tick();
    tests++; if (claim_ack_o !== 1'b0 || top1 !== 5'd0) begin fails++; $display("FAIL b2b_done: ack %b top1 %0d want 0/0", claim_ack_o, top1); end
  endtask

  task automatic test_dlv_and_reset();
    cfg(2'd0, 2'd0, 5'd6);
    cfg(2'd0, 2'd3, 5'd0);
    msi(2'd0, 5'd6);
    tests++; if (top0 !== 5'd6 || irq_o[0] !== 1'b0) begin fails++; $display("FAIL dlv_off: top0 %0d irq0 %b want 6/0", top0, irq_o[0]); end
    cfg(2'd0, 2'd3, 5'd1);
    tests++; if (irq_o[0] !== 1'b1) begin fails++; $display("FAIL dlv_on: irq0 %b want 1", irq_o[0]); end
    claim_valid_i = 1'b1; claim_file_i = 2'd1;
    tick();
    claim_valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    tests++; if (claim_ack_o !== 1'b0 || claim_id_o !== 5'd0 || msi_ready_o !== 1'b0) begin fails++; $display("FAIL midrst_ctrl: ack %b id %0d rdy %b want 0/0/0", claim_ack_o, claim_id_o, msi_ready_o); end
    tests++; if (topei_o !== 10'd0 || irq_o !== 2'b00) begin fails++; $display("FAIL midrst_top: topei %h irq %b want 0/00", topei_o, irq_o); end
    #3 rst_ni = 1'b1;
    tick(); tick();
    tests++; if (topei_o !== 10'd0 || claim_ack_o !== 1'b0 || msi_ready_o !== 1'b1) begin fails++; $display("FAIL post_rst: topei %h ack %b rdy %b want 0/0/1", topei_o, claim_ack_o, msi_ready_o); end
  endtask

  initial begin
    test_reset();
    test_basic_msi();
    test_threshold();
    test_drop();
    test_claim_msi_same();
    test_back_to_back();
    test_dlv_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
